// File: rtl/srp_buf_pkg.sv
// Shared sizing for the time-synchronizer sample buffer (RAM, writer and reader sides)
// plus the reader's state encoding.
package srp_buf_pkg;
    localparam int SRP_ADDR_W = 12;
    localparam int SRP_DATA_W = 32;
    localparam int SRP_DEPTH  = 2096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rdr_state_e;
endpackage

// File: rtl/srp_skid_buf.sv
// Two-entry FIFO that absorbs the RAM read latency and downstream backpressure.
// The head entry is presented combinationally; storage is cleared on reset.
import srp_buf_pkg::*;

module srp_skid_buf #(
    parameter int W = SRP_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);
    logic [1:0][W-1:0] mem_q;
    logic              wr_q, rd_q;
    logic [1:0]        cnt_q, cnt_d;

    assign cnt_d   = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

    // Upstream credit logic must keep us from ever overflowing or underflowing.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && !pop_i && cnt_q == 2'd2));
            assert (!(pop_i && cnt_q == 2'd0));
        end
    end
endmodule

// File: rtl/srp_bram_reader.sv
// Read sequencer: streams a window of buffer RAM words on valid/ready at one word per cycle.
// Optional SRP_RDR_LAST_EN adds an m_last output flagging the final beat of a window.
import srp_buf_pkg::*;

module srp_bram_reader #(
    parameter int ADDR_W = SRP_ADDR_W,
    parameter int DATA_W = SRP_DATA_W,
    parameter int DEPTH  = SRP_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
`ifdef SRP_RDR_LAST_EN
    ,
    output logic              m_last
`endif
);
`ifdef SRP_RDR_LAST_EN
    localparam int BW = DATA_W + 1;
`else
    localparam int BW = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rdr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_eff;
    logic [ADDR_W:0]   rem_q, rem_d, len_eff;
    logic              inflight_q, zdone_q;
    logic              start_ok, pop, issue, last_issue, credit_ok, drain_done;
    logic [1:0]        buf_count;
    logic [BW-1:0]     buf_head, buf_din;

    assign start_ok = start && (state_q == ST_IDLE);
    assign len_eff  = (length > DEPTH_L) ? DEPTH_L : length;
    // A single subtraction suffices because DEPTH covers at least half the address space.
    assign base_eff = ({1'b0, base_addr} >= DEPTH_L) ? ADDR_W'({1'b0, base_addr} - DEPTH_L)
                                                     : base_addr;

    assign m_valid    = (buf_count != 2'd0);
    assign pop        = m_valid && m_ready;
    assign credit_ok  = ({1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
    assign issue      = (state_q == ST_RUN) && (rem_q != '0) && credit_ok;
    assign last_issue = issue && (rem_q == (ADDR_W + 1)'(1));
    assign drain_done = (state_q == ST_DRAIN) && !inflight_q &&
                        ((buf_count == 2'd0) || (buf_count == 2'd1 && pop));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && len_eff != '0) state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = drain_done || zdone_q;
        bram_en   = issue;
        bram_we   = 1'b0;
        bram_addr = addr_q;
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (start_ok) begin
            addr_d = base_eff;
            rem_d  = len_eff;
        end else if (issue) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            zdone_q    <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
            zdone_q    <= start_ok && (len_eff == '0);
        end
    end

`ifdef SRP_RDR_LAST_EN
    logic inflight_last_q;
    always_ff @(posedge clk) begin
        if (rst) inflight_last_q <= 1'b0;
        else     inflight_last_q <= last_issue;
    end
    assign buf_din = {inflight_last_q, bram_dout};
    assign m_last  = m_valid && buf_head[DATA_W];
`else
    assign buf_din = bram_dout;
`endif
    assign m_data = buf_head[DATA_W-1:0];

    srp_skid_buf #(.W(BW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   (buf_din),
        .pop_i   (pop),
        .count_o (buf_count),
        .head_o  (buf_head)
    );
endmodule

// File: tb/tb_srp_bram_reader.sv
// Directed bench for srp_bram_reader: window table plus hand-written reset sequence.
module tb_srp_bram_reader;
    localparam int DEPTH = 2096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] length = '0;
    logic        busy, done, bram_en, bram_we, m_valid;
    logic        m_ready = 1'b0;
    logic [11:0] bram_addr;
    logic [31:0] bram_dout = '0;
    logic [31:0] m_data;
`ifdef SRP_RDR_LAST_EN
    logic        m_last;
`endif

    int nchk = 0;
    int nerr = 0;

    srp_bram_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef SRP_RDR_LAST_EN
        , .m_last(m_last)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
    endfunction

    // RAM model: registered read, one cycle latency
    always @(posedge clk) if (bram_en) bram_dout <= word(int'(bram_addr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            0: return 1'b1;
            1: return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    typedef struct {
        int base;
        int len;
        int mode;       // 0 ready high, 1 toggle 1,0,0,1, 2 random
        int exp_beats;
        int exp_first;  // first word address after modulo reduction
        int exp_done;   // done cycle relative to start, -1 when stalled
        int restart;    // cycle at which a second start is pulsed, 0 none
    } vec_t;

    task automatic run_window(input vec_t v);
        int nb = 0, issued = 0, first_v = -1, done_cyc = -1, ndone = 0;
        int budget, tail;
        logic pv_stall = 1'b0;
        logic [31:0] pdata = '0;
        budget = v.exp_beats * 4 + 40;
        tail = budget;
        @(negedge clk);
        start = 1'b1; base_addr = 12'(v.base); length = 13'(v.len); m_ready = rdy(v.mode, 0);
        for (int cyc = 1; cyc < budget && cyc <= tail; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (v.restart != 0 && cyc == v.restart) begin
                start = 1'b1; base_addr = 12'd500; length = 13'd2;
            end
            m_ready = rdy(v.mode, cyc);
            #1;
            if (cyc == 1) chk("busy_after_start", 32'(busy), 32'(v.exp_beats > 0));
            if (bram_en) begin
                chk("read_credit", 32'((issued - nb - int'(m_valid && m_ready)) < 2), 32'd1);
                chk("no_extra_read", 32'(issued < v.exp_beats), 32'd1);
                issued++;
            end
            if (pv_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", m_data, pdata);
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                chk("beat_data", m_data, word((v.exp_first + nb) % DEPTH));
`ifdef SRP_RDR_LAST_EN
                chk("m_last", 32'(m_last), 32'(nb == v.exp_beats - 1));
`endif
                nb++;
            end
            pv_stall = m_valid && !m_ready;
            pdata = m_data;
            if (ndone == 1 && cyc == done_cyc + 1) chk("busy_drop", 32'(busy), 32'd0);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    done_cyc = cyc;
                    tail = cyc + 10;
                    chk("done_with_last_beat", 32'(nb), 32'(v.exp_beats));
                end
            end
        end
        chk("done_count", 32'(ndone), 32'd1);
        chk("beat_count", 32'(nb), 32'(v.exp_beats));
        if (v.exp_done >= 0) chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        chk("first_valid_cycle", 32'(first_v), (v.exp_beats > 0) ? 32'd3 : 32'hFFFF_FFFF);
        m_ready = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{base: 0,    len: 8,    mode: 0, exp_beats: 8,    exp_first: 0,    exp_done: 10,   restart: 0};
        vecs[1] = '{base: 2094, len: 4,    mode: 0, exp_beats: 4,    exp_first: 2094, exp_done: 6,    restart: 0};
        vecs[2] = '{base: 5,    len: 16,   mode: 1, exp_beats: 16,   exp_first: 5,    exp_done: -1,   restart: 0};
        vecs[3] = '{base: 7,    len: 0,    mode: 0, exp_beats: 0,    exp_first: 7,    exp_done: 1,    restart: 0};
        vecs[4] = '{base: 3000, len: 3,    mode: 0, exp_beats: 3,    exp_first: 904,  exp_done: 5,    restart: 0};
        vecs[5] = '{base: 10,   len: 6,    mode: 0, exp_beats: 6,    exp_first: 10,   exp_done: 8,    restart: 2};
        vecs[6] = '{base: 2000, len: 5000, mode: 0, exp_beats: 2096, exp_first: 2000, exp_done: 2098, restart: 0};
        vecs[7] = '{base: 50,   len: 1,    mode: 0, exp_beats: 1,    exp_first: 50,   exp_done: 3,    restart: 0};
        vecs[8] = '{base: 2090, len: 12,   mode: 2, exp_beats: 12,   exp_first: 2090, exp_done: -1,   restart: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_window(vecs[i]);

        // Reset in the middle of a window, after five beats have transferred
        begin
            int nb = 0;
            int bad_done = 0;
            @(negedge clk);
            start = 1'b1; base_addr = 12'd0; length = 13'd20; m_ready = 1'b1;
            for (int cyc = 1; cyc < 40 && nb < 5; cyc++) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                if (m_valid && m_ready) begin
                    chk("rst_seq_beat", m_data, word(nb));
                    nb++;
                end
            end
            chk("rst_seq_beats_before", 32'(nb), 32'd5);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_done", 32'(done), 32'd0);
            chk("midrst_bram_en", 32'(bram_en), 32'd0);
            chk("midrst_bram_addr", 32'(bram_addr), 32'd0);
            chk("midrst_m_valid", 32'(m_valid), 32'd0);
            chk("midrst_m_data", m_data, 32'd0);
            for (int cyc = 0; cyc < 8; cyc++) begin
                @(negedge clk);
                #1;
                if (done || m_valid || busy) bad_done++;
            end
            chk("midrst_quiet", 32'(bad_done), 32'd0);
            run_window('{base: 100, len: 3, mode: 0, exp_beats: 3, exp_first: 100, exp_done: 5, restart: 0});
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/srp_bram_reader.md
Name: srp_bram_reader

Overview:
Read-side sequencer for the time-synchronizer sample buffer. It drives the single-port buffer RAM (en/we/addr, 1-cycle registered read data) and streams a programmed window of 32-bit words out on a valid/ready interface for the Shapiro-Rudin-Park correlator. It absorbs the RAM read latency and downstream backpressure through a 2-entry output buffer, so throughput is one word per cycle with no data loss.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 32, RAM/stream data width
DEPTH, 2096, RAM word count; address wrap point

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse: begin a read window (ignored while busy)
base_addr  in  ADDR_W  first word address, sampled with start
length  in  ADDR_W+1  word count, sampled with start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the final word is accepted downstream
bram_en  out  1  RAM enable
bram_we  out  1  RAM write enable, tied 0
bram_addr  out  ADDR_W  RAM address
bram_dout  in  DATA_W  RAM read data, valid the cycle after bram_en
m_data  out  DATA_W  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready; a beat transfers when m_valid && m_ready

Behaviour:
- Reset: busy=0, done=0, bram_en=0, bram_we=0, bram_addr=0, m_valid=0, m_data=0. The buffer is flushed, the in-flight flag is cleared, and FSM=IDLE. Reset mid-window aborts it with no done pulse. Read data returning after reset is discarded.
- FSM IDLE -> RUN on start. RUN -> DRAIN when the last read is issued. DRAIN -> IDLE when the buffer is empty, the in-flight flag is clear, and the last beat has transferred. done pulses that same cycle and busy drops the next cycle.
- length=0: IDLE -> IDLE, no RAM access, done pulses the cycle after start, busy stays 0.
- length>DEPTH: clamped to DEPTH.
- Addressing: rd_addr=base_addr at start and increments per issued read. DEPTH-1 wraps to 0. base_addr>=DEPTH is reduced modulo DEPTH.
- Read issue (RUN only): bram_en=1 when reads_remaining>0 and (buf_count + inflight - pop) < 2, where pop = m_valid && m_ready this cycle. bram_en and bram_addr are combinational from state. inflight is a register set on each issue, meaning the data lands next cycle.
- Capture: when inflight=1, bram_dout is written into the buffer at the clock edge.
- Latency: start at cycle 0, bram_en in cycle 1, m_valid in cycle 3.
- Throughput: with m_ready held high, one beat per cycle continuously.
- Ordering: beats leave in issue order. m_data and m_valid are stable while m_valid && !m_ready.
- A start pulse during busy is ignored entirely.
- The buffer never overflows; the credit rule guarantees this. Overflow is a verification assertion.

Optional Feature:
SRP_RDR_LAST_EN
- Defined: adds output port m_last (1 bit), high with the final beat of a window, reset 0, held stable under backpressure.
- Undefined: no m_last port, no related logic.

Decomposition:
- Package srp_buf_pkg holds ADDR_W, DATA_W, and DEPTH defaults, shared with the buffer RAM and the writer side.
- Sub-module srp_skid_buf: 2-entry FIFO with push, pop, count, and head data. The FSM, counters, and credit logic stay in the top.

Test Plan:
1. base=0, length=8, m_ready=1 -> m_valid in cycle 3, data = RAM[0..7] on 8 consecutive cycles, done in the cycle of beat 8, busy low the next cycle.
2. base=2094, length=4 -> addresses 2094, 2095, 0, 1, data in that order, no stall.
3. length=16 with m_ready toggling 1,0,0,1 repeating -> all 16 words in order, none duplicated, m_data stable during stalls, bram_en never raised with buffer full plus inflight.
4. length=0 -> bram_en never asserted, done exactly 1 cycle after start, no m_valid.
5. rst asserted for 1 cycle mid-window after 5 beats -> all outputs 0 the next cycle, no done, and a new start (base=100, length=3) yields RAM[100..102] only.
6. start re-pulsed while busy, with SRP_RDR_LAST_EN defined -> second start ignored, exactly one done, m_last high only on the final beat.
